// File: rtl/hamming_pkg.sv
// Shared Hamming 15:11 definitions used by the encoder, the decoder and
// any checker that needs the codeword layout.
package hamming_pkg;

  localparam int N_CODIGO   = 15;
  localparam int N_DADOS    = 11;
  localparam int N_SINDROME = 4;

  // Codeword bit index holding data bit e0..e10 (non-power-of-two positions).
  localparam logic [N_DADOS-1:0][3:0] POS_DADOS = {
    4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2
  };

  // Gather the 11 data bits out of a (corrected) codeword.
  function automatic logic [N_DADOS-1:0] extrai_dados(input logic [N_CODIGO-1:0] cw);
    logic [N_DADOS-1:0] d;
    d = '0;
    for (int k = 0; k < N_DADOS; k++) begin
      d[k] = cw[POS_DADOS[k]];
    end
    return d;
  endfunction

endpackage

// File: rtl/decodifica_hamming_if.sv
// Codeword-in / data-out stream bundle for the Hamming 15:11 decoder.
// master: upstream/downstream environment; slave: the decoder.
interface decodifica_hamming_if;
  import hamming_pkg::*;

  logic [N_CODIGO-1:0]   entrada;
  logic                  entrada_valida;
  logic                  entrada_pronta;
  logic [N_DADOS-1:0]    saida;
  logic                  saida_valida;
  logic                  saida_pronta;
  logic [N_SINDROME-1:0] sindrome;
  logic                  corrigido;

  modport master (
    output entrada, entrada_valida, saida_pronta,
    input  entrada_pronta, saida, saida_valida, sindrome, corrigido
  );

  modport slave (
    input  entrada, entrada_valida, saida_pronta,
    output entrada_pronta, saida, saida_valida, sindrome, corrigido
  );

endinterface

// File: rtl/sindrome_hamming.sv
// Combinational Hamming 15:11 syndrome: XOR of (i+1) over every set bit i.
// A zero result means the word is a valid codeword.
module sindrome_hamming
  import hamming_pkg::*;
(
  input  logic [N_CODIGO-1:0]   i_codigo,
  output logic [N_SINDROME-1:0] o_sindrome
);

  logic [N_SINDROME-1:0] w_acc;

  // Accumulate the position number of every set bit
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N_CODIGO; i++) begin
      if (i_codigo[i]) w_acc = w_acc ^ N_SINDROME'(i + 1);
    end
  end

  assign o_sindrome = w_acc;

endmodule

// File: rtl/decodifica_hamming.sv
// Two-stage Hamming 15:11 single-error-correcting decoder with valid/ready
// flow control. Optional statistics counters are built when the macro
// HAMMING_CONTADORES_EN is defined.
module decodifica_hamming
  import hamming_pkg::*;
#(
  parameter int LARGURA_CNT = 16
)
(
  input  logic                   clk,
  input  logic                   rst,
  decodifica_hamming_if.slave    bus
`ifdef HAMMING_CONTADORES_EN
  ,
  output logic [LARGURA_CNT-1:0] cnt_palavras,
  output logic [LARGURA_CNT-1:0] cnt_corrigidos
`endif
);

  logic [N_SINDROME-1:0] w_sindrome_p0;

  logic [N_CODIGO-1:0]   r_codigo_p1;
  logic [N_SINDROME-1:0] r_sindrome_p1;
  logic                  r_vld_p1;

  logic [N_DADOS-1:0]    r_dados_p2;
  logic [N_SINDROME-1:0] r_sindrome_p2;
  logic                  r_corrigido_p2;
  logic                  r_vld_p2;

  logic                  w_s1_avanca;
  logic                  w_s2_avanca;
  logic                  w_entrega;

  // Flip bit s-1 when the syndrome is non-zero; parity positions included.
  function automatic logic [N_CODIGO-1:0] corrige(input logic [N_CODIGO-1:0] cw,
                                                  input logic [N_SINDROME-1:0] s);
    logic [N_CODIGO-1:0] mask;
    mask = '0;
    if (s != '0) mask = N_CODIGO'(1) << (s - N_SINDROME'(1));
    return cw ^ mask;
  endfunction

  sindrome_hamming u_sindrome (
    .i_codigo   (bus.entrada),
    .o_sindrome (w_sindrome_p0)
  );

  // Each stage moves when its successor can take the word (or it is empty).
  assign w_s2_avanca    = !r_vld_p2 || bus.saida_pronta;
  assign w_s1_avanca    = !r_vld_p1 || w_s2_avanca;
  assign w_entrega      = r_vld_p2 && bus.saida_pronta;
  assign bus.entrada_pronta = w_s1_avanca;

  // ---- stage 1: codeword + syndrome ----
  // S1 occupancy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_avanca) begin
      r_vld_p1 <= bus.entrada_valida;
    end
  end

  // S1 data capture on an input handshake
  always_ff @(posedge clk) begin
    if (w_s1_avanca && bus.entrada_valida) begin
      r_codigo_p1   <= bus.entrada;
      r_sindrome_p1 <= w_sindrome_p0;
    end
  end

  // ---- stage 2: corrected data, syndrome, correction flag ----
  // S2 register; holds its contents while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2       <= 1'b0;
      r_dados_p2     <= '0;
      r_sindrome_p2  <= '0;
      r_corrigido_p2 <= 1'b0;
    end else if (w_s2_avanca) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_dados_p2     <= extrai_dados(corrige(r_codigo_p1, r_sindrome_p1));
        r_sindrome_p2  <= r_sindrome_p1;
        r_corrigido_p2 <= (r_sindrome_p1 != '0);
      end
    end
  end

  assign bus.saida        = r_dados_p2;
  assign bus.sindrome     = r_sindrome_p2;
  assign bus.corrigido    = r_corrigido_p2;
  assign bus.saida_valida = r_vld_p2;

`ifdef HAMMING_CONTADORES_EN
  logic [LARGURA_CNT-1:0] r_cnt_palavras;
  logic [LARGURA_CNT-1:0] r_cnt_corrigidos;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [LARGURA_CNT-1:0] satura_inc(input logic [LARGURA_CNT-1:0] v);
    return (&v) ? v : v + LARGURA_CNT'(1);
  endfunction

  // Statistics counters advance only on an output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_palavras   <= '0;
      r_cnt_corrigidos <= '0;
    end else if (w_entrega) begin
      r_cnt_palavras <= satura_inc(r_cnt_palavras);
      if (r_corrigido_p2) r_cnt_corrigidos <= satura_inc(r_cnt_corrigidos);
    end
  end

  assign cnt_palavras   = r_cnt_palavras;
  assign cnt_corrigidos = r_cnt_corrigidos;
`endif

endmodule

// File: tb/tb_decodifica_hamming.sv
// Directed bench for decodifica_hamming: reset state, latency, single-bit
// corrections, full sweep, back-pressure, mid-flight reset and (with
// HAMMING_CONTADORES_EN) counter totals and saturation.
module tb_decodifica_hamming;
  import hamming_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decodifica_hamming_if bus ();

`ifdef HAMMING_CONTADORES_EN
  logic [15:0] cnt_palavras, cnt_corrigidos;
  decodifica_hamming #(.LARGURA_CNT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cnt_palavras(cnt_palavras), .cnt_corrigidos(cnt_corrigidos)
  );

  decodifica_hamming_if bus4 ();
  logic [3:0] c4_palavras, c4_corrigidos;
  decodifica_hamming #(.LARGURA_CNT(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .cnt_palavras(c4_palavras), .cnt_corrigidos(c4_corrigidos)
  );
`else
  decodifica_hamming #(.LARGURA_CNT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  int passed = 0;
  int total  = 0;
  int nfail  = 0;

  logic [15:0] fila[$];
  logic [15:0] esperado;
  logic [14:0] bp_cw[5];
  logic [15:0] bp_exp[5];
  logic [10:0] capturado;
  logic        tem_captura;
  logic [10:0] d;
  int          e, idx, rcv, cyc, acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder: data into non-power-of-two positions, then parities.
  function automatic logic [14:0] codifica(input logic [10:0] dd);
    logic [14:0] cw;
    int k;
    logic par;
    cw = '0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = dd[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if (((p & (1 << b)) != 0) && (p != (1 << b))) par = par ^ cw[p-1];
      end
      cw[(1 << b) - 1] = par;
    end
    return cw;
  endfunction

  function automatic logic [14:0] erro(input int pos);
    logic [14:0] m;
    m = '0;
    if (pos > 0) m[pos-1] = 1'b1;
    return m;
  endfunction

  // One isolated word with downstream always ready; checks two-stage latency.
  task automatic envia_um(input string tag, input logic [14:0] cw, input logic [10:0] ed,
                          input logic [3:0] es, input logic ec);
    bus.saida_pronta   = 1'b1;
    bus.entrada        = cw;
    bus.entrada_valida = 1'b1;
    #1;
    chk({tag, "_pronta"}, 32'(bus.entrada_pronta), 32'd1);
    tick();
    bus.entrada_valida = 1'b0;
    #1;
    chk({tag, "_lat1"}, 32'(bus.saida_valida), 32'd0);
    tick();
    chk({tag, "_valida"}, 32'(bus.saida_valida), 32'd1);
    chk({tag, "_saida"}, 32'(bus.saida), 32'(ed));
    chk({tag, "_sind"}, 32'(bus.sindrome), 32'(es));
    chk({tag, "_corr"}, 32'(bus.corrigido), 32'(ec));
    tick();
    chk({tag, "_vazio"}, 32'(bus.saida_valida), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.entrada = '0; bus.entrada_valida = 1'b0; bus.saida_pronta = 1'b0;
`ifdef HAMMING_CONTADORES_EN
    bus4.entrada = '0; bus4.entrada_valida = 1'b0; bus4.saida_pronta = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_valida", 32'(bus.saida_valida), 32'd0);
    chk("rst_pronta", 32'(bus.entrada_pronta), 32'd1);
    chk("rst_saida", 32'(bus.saida), 32'd0);
    chk("rst_sind", 32'(bus.sindrome), 32'd0);
    chk("rst_corr", 32'(bus.corrigido), 32'd0);
`ifdef HAMMING_CONTADORES_EN
    chk("rst_cnt_pal", 32'(cnt_palavras), 32'd0);
    chk("rst_cnt_cor", 32'(cnt_corrigidos), 32'd0);
`endif
    tick();

    // Directed words
    envia_um("limpo", 15'h0007, 11'h001, 4'd0, 1'b0);
    envia_um("erro_p1", 15'h7FFE, 11'h7FF, 4'd1, 1'b1);
    envia_um("erro_e10", 15'h4007, 11'h001, 4'd15, 1'b1);
    envia_um("erro_p8", 15'h0087, 11'h001, 4'd8, 1'b1);
    envia_um("erro_e0", 15'h0003, 11'h001, 4'd3, 1'b1);

    // Back-pressure: continuous stream while downstream stalls for 5 cycles
    for (int k = 0; k < 5; k++) begin
      bp_cw[k]  = codifica(11'h2A0 + 11'(k)) ^ erro(k + 1);
      bp_exp[k] = {1'b1, 4'(k + 1), 11'h2A0 + 11'(k)};
    end
    fila.delete();
    acc = 0;
    tem_captura = 1'b0;
    bus.saida_pronta = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.entrada        = bp_cw[acc];
      bus.entrada_valida = 1'b1;
      #1;
      if (bus.entrada_pronta) begin
        fila.push_back(bp_exp[acc]);
        acc++;
      end
      tick();
      if (bus.saida_valida) begin
        if (!tem_captura) begin
          capturado   = bus.saida;
          tem_captura = 1'b1;
          chk("bp_primeira", 32'(bus.saida), 32'(bp_exp[0][10:0]));
        end else begin
          chk("bp_estavel", 32'(bus.saida), 32'(capturado));
        end
      end
    end
    chk("bp_aceitas", 32'(acc), 32'd2);
    #1;
    chk("bp_pronta_baixo", 32'(bus.entrada_pronta), 32'd0);
    bus.entrada_valida = 1'b0;
    bus.saida_pronta   = 1'b1;
    rcv = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.saida_valida) begin
        esperado = (fila.size() > 0) ? fila.pop_front() : 16'hFFFF;
        chk("bp_ordem", 32'({bus.corrigido, bus.sindrome, bus.saida}), 32'(esperado));
        rcv++;
      end
      tick();
    end
    chk("bp_entregues", 32'(rcv), 32'd2);

    // Full sweep: every data word, clean and with each single-bit flip
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fila.delete();
    idx = 0; rcv = 0; cyc = 0;
    while (rcv < 32768 && cyc < 90000) begin
      bus.saida_pronta = ($urandom_range(0, 3) != 0);
      if (idx < 32768) begin
        d = 11'(idx >> 4);
        e = idx & 15;
        bus.entrada        = codifica(d) ^ erro(e);
        bus.entrada_valida = 1'b1;
      end else begin
        bus.entrada_valida = 1'b0;
      end
      #1;
      if (bus.entrada_valida && bus.entrada_pronta) begin
        fila.push_back({(e != 0), 4'(e), d});
        idx++;
      end
      if (bus.saida_valida && bus.saida_pronta) begin
        esperado = (fila.size() > 0) ? fila.pop_front() : 16'hFFFF;
        chk("varredura", 32'({bus.corrigido, bus.sindrome, bus.saida}), 32'(esperado));
        rcv++;
      end
      tick();
      cyc++;
    end
    bus.entrada_valida = 1'b0;
    chk("varredura_total", 32'(rcv), 32'd32768);
`ifdef HAMMING_CONTADORES_EN
    chk("cnt_palavras", 32'(cnt_palavras), 32'd32768);
    chk("cnt_corrigidos", 32'(cnt_corrigidos), 32'd30720);
`endif

    // Reset with two words in flight
    bus.saida_pronta = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.entrada        = bp_cw[k];
      bus.entrada_valida = 1'b1;
      tick();
    end
    bus.entrada_valida = 1'b0;
    chk("voo_cheio", 32'(bus.saida_valida), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.saida_pronta = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("voo_descartado", 32'(bus.saida_valida), 32'd0);
      tick();
    end
`ifdef HAMMING_CONTADORES_EN
    chk("voo_cnt_pal", 32'(cnt_palavras), 32'd0);

    // Saturation of the 4-bit counters: 20 corrupted words
    bus4.saida_pronta = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus4.entrada        = codifica(11'(k)) ^ erro(4);
      bus4.entrada_valida = 1'b1;
      tick();
    end
    bus4.entrada_valida = 1'b0;
    repeat (4) tick();
    chk("sat_palavras", 32'(c4_palavras), 32'd15);
    chk("sat_corrigidos", 32'(c4_corrigidos), 32'd15);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
